// File: rtl/adc_avg_filter.sv
// adc_avg_filter
// Conditions raw ADC samples for the fan controller's PID path. Consecutive
// accepted samples are block-averaged over 2^AVG_LOG2 samples and the result
// is presented as a registered ADC_value_o with a one-cycle ADC_valid_o
// pulse. A sensor watchdog forces FAULT_VALUE (full fan demand) and raises
// fault_o when no sample has been accepted for TIMEOUT_CYCLES enabled cycles.
//
// Ports:
//   clk_i          system clock
//   rstn_i         asynchronous active-low reset
//   clk_en_i       global clock enable; state advances only while high
//   sample_i       raw unsigned ADC sample
//   sample_valid_i sample_i is valid this cycle
//   flush_i        drop the partial window and restart the watchdog
//   ADC_value_o    registered average, or FAULT_VALUE while faulted
//   ADC_valid_o    one-cycle pulse whenever ADC_value_o is updated
//   fault_o        watchdog fault flag
//   state_dbg_o    FSM state (0 = NORMAL, 1 = FAULT) for observation
//
// Handshake: sample_valid_i is a valid-only strobe with no back-pressure.
// A sample is consumed on every rising edge where sample_valid_i and
// clk_en_i are high and flush_i is low; otherwise it is ignored.

module adc_avg_filter #(
  parameter int unsigned ADC_BITWIDTH   = 8,
  parameter int unsigned AVG_LOG2       = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter logic [ADC_BITWIDTH-1:0] FAULT_VALUE = {ADC_BITWIDTH{1'b1}}
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    clk_en_i,
  input  logic [ADC_BITWIDTH-1:0] sample_i,
  input  logic                    sample_valid_i,
  input  logic                    flush_i,
  output logic [ADC_BITWIDTH-1:0] ADC_value_o,
  output logic                    ADC_valid_o,
  output logic                    fault_o,
  output logic                    state_dbg_o
);

  // Accumulator holds up to 2^AVG_LOG2 full-scale samples, so it never wraps.
  localparam int unsigned ACC_W = ADC_BITWIDTH + AVG_LOG2;
  // A zero-width counter is not legal; with AVG_LOG2 = 0 it is kept but unused.
  localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_FAULT  = 1'b1
  } state_t;

  state_t            state;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic [WD_W-1:0]   wd_cnt;

  logic [ACC_W-1:0]        sum;
  logic [ADC_BITWIDTH-1:0] avg;
  logic                    last_sample;
  logic                    wd_saturated;
  logic                    wd_expiring;

  assign sum          = acc + ACC_W'(sample_i);
  assign avg          = ADC_BITWIDTH'(sum >> AVG_LOG2);
  assign last_sample  = (AVG_LOG2 == 0) || (cnt == {CNT_W{1'b1}});
  assign wd_saturated = (wd_cnt == WD_W'(TIMEOUT_CYCLES));
  // True on the idle edge that brings the watchdog up to TIMEOUT_CYCLES.
  assign wd_expiring  = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  assign state_dbg_o = state;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= ST_NORMAL;
      acc         <= '0;
      cnt         <= '0;
      wd_cnt      <= '0;
      ADC_value_o <= '0;
      ADC_valid_o <= 1'b0;
      fault_o     <= 1'b0;
    end else begin
      // The pulse lasts one clk_i cycle even when the enable is low.
      ADC_valid_o <= 1'b0;
      if (clk_en_i) begin
        if (flush_i) begin
          // Flush wins over a coincident sample; outputs and state are kept.
          acc    <= '0;
          cnt    <= '0;
          wd_cnt <= '0;
        end else if (sample_valid_i) begin
          wd_cnt <= '0;
          if (last_sample) begin
            // A completed window is the only way out of FAULT.
            ADC_value_o <= avg;
            ADC_valid_o <= 1'b1;
            fault_o     <= 1'b0;
            state       <= ST_NORMAL;
            acc         <= '0;
            cnt         <= '0;
          end else begin
            acc <= sum;
            cnt <= cnt + CNT_W'(1);
          end
        end else begin
          if (!wd_saturated) begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
          // Only NORMAL reacts to the timeout, so FAULT produces one pulse.
          if (state == ST_NORMAL && wd_expiring) begin
            state       <= ST_FAULT;
            fault_o     <= 1'b1;
            ADC_value_o <= FAULT_VALUE;
            ADC_valid_o <= 1'b1;
            acc         <= '0;
            cnt         <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_avg_filter.sv
`timescale 1ns/1ps

module tb_adc_avg_filter;

  localparam int unsigned W       = 8;
  localparam int unsigned LOG2    = 2;
  localparam int unsigned TIMEOUT = 16;

  // ---------------- clock / reset ----------------
  logic         clk_i = 1'b0;
  logic         rstn_i = 1'b0;
  logic         clk_en_i = 1'b0;
  logic [W-1:0] sample_i = '0;
  logic         sample_valid_i = 1'b0;
  logic         flush_i = 1'b0;
  logic [W-1:0] ADC_value_o;
  logic         ADC_valid_o;
  logic         fault_o;
  logic         state_dbg_o;

  always #500 clk_i = ~clk_i;  // 1 MHz

  adc_avg_filter #(
    .ADC_BITWIDTH  (W),
    .AVG_LOG2      (LOG2),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .clk_en_i      (clk_en_i),
    .sample_i      (sample_i),
    .sample_valid_i(sample_valid_i),
    .flush_i       (flush_i),
    .ADC_value_o   (ADC_value_o),
    .ADC_valid_o   (ADC_valid_o),
    .fault_o       (fault_o),
    .state_dbg_o   (state_dbg_o)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one edge and settle 1 ns past it before anything is sampled.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [W-1:0] s);
    sample_i       = s;
    sample_valid_i = 1'b1;
    tick();
    sample_valid_i = 1'b0;
  endtask

  // Sends a window minus its last sample, checking no update happens early.
  task automatic send_partial(input string tag, input logic [W-1:0] s, input int n,
                              input logic [W-1:0] held);
    for (int i = 0; i < n; i++) begin
      send(s);
      check({tag, "_no_early_valid"}, ADC_valid_o, 0);
    end
    check({tag, "_value_held"}, ADC_value_o, held);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pulses;

    // Reset state, checked while reset is held.
    #200;
    check("reset_value", ADC_value_o, 0);
    check("reset_valid", ADC_valid_o, 0);
    check("reset_fault", fault_o, 0);
    check("reset_state", state_dbg_o, 0);
    #1300 rstn_i = 1'b1;
    clk_en_i = 1'b1;
    tick();

    // 10+20+30+41 = 101, 101>>2 = 25.
    send(10); check("w1_s1_valid", ADC_valid_o, 0);
    send(20); check("w1_s2_valid", ADC_valid_o, 0);
    send(30); check("w1_s3_valid", ADC_valid_o, 0);
    send(41);
    check("w1_value", ADC_value_o, 25);
    check("w1_valid", ADC_valid_o, 1);
    check("w1_fault", fault_o, 0);
    tick();
    check("w1_valid_one_cycle", ADC_valid_o, 0);
    check("w1_value_hold", ADC_value_o, 25);

    // Full-scale window: 4*255 = 1020 fits, average 255.
    send_partial("full", 255, 3, 25);
    send(255);
    check("full_value", ADC_value_o, 255);
    check("full_valid", ADC_valid_o, 1);
    send_partial("zero", 0, 3, 255);
    send(0);
    check("zero_value", ADC_value_o, 0);
    check("zero_valid", ADC_valid_o, 1);

    // Enable low freezes the window and watchdog: (50+50+70+70)/4 = 60.
    send(50); send(50);
    clk_en_i = 1'b0;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      pulses += int'(ADC_valid_o);
    end
    check("en_low_pulses", pulses, 0);
    check("en_low_fault", fault_o, 0);
    clk_en_i = 1'b1;
    send(70);
    check("en_low_partial_valid", ADC_valid_o, 0);
    send(70);
    check("en_value", ADC_value_o, 60);
    check("en_valid", ADC_valid_o, 1);
    clk_en_i = 1'b0;
    tick();
    check("valid_clears_en_low", ADC_valid_o, 0);
    check("value_holds_en_low", ADC_value_o, 60);
    clk_en_i = 1'b1;

    // Watchdog: fault on exactly the 16th idle enabled edge.
    pulses = 0;
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      tick();
      pulses += int'(ADC_valid_o);
    end
    check("wd_no_fault_early", fault_o, 0);
    check("wd_value_before", ADC_value_o, 60);
    tick();
    pulses += int'(ADC_valid_o);
    check("wd_fault", fault_o, 1);
    check("wd_state", state_dbg_o, 1);
    check("wd_value", ADC_value_o, 255);
    check("wd_valid", ADC_valid_o, 1);
    check("wd_pulse_count", pulses, 1);
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      pulses += int'(ADC_valid_o);
    end
    check("fault_no_more_pulses", pulses, 0);
    check("fault_sticky", fault_o, 1);

    // Recovery needs a full window of 100s.
    send_partial("recover", 100, 3, 255);
    check("recover_still_fault", fault_o, 1);
    send(100);
    check("recover_fault", fault_o, 0);
    check("recover_state", state_dbg_o, 0);
    check("recover_value", ADC_value_o, 100);
    check("recover_valid", ADC_valid_o, 1);

    // Flush with a coincident sample: both 200s and the flushed one are lost.
    send(200); send(200);
    sample_i = 200; sample_valid_i = 1'b1; flush_i = 1'b1;
    tick();
    sample_valid_i = 1'b0; flush_i = 1'b0;
    check("flush_valid", ADC_valid_o, 0);
    check("flush_value_kept", ADC_value_o, 100);
    send_partial("post_flush", 40, 3, 100);
    send(40);
    check("flush_value", ADC_value_o, 40);
    check("flush_valid_pulse", ADC_valid_o, 1);

    // Asynchronous reset mid-window, between edges.
    send(250); send(250);
    #300 rstn_i = 1'b0;
    #1;
    check("async_rst_value", ADC_value_o, 0);
    check("async_rst_fault", fault_o, 0);
    check("async_rst_valid", ADC_valid_o, 0);
    #100 rstn_i = 1'b1;
    send_partial("post_rst", 8, 3, 0);
    send(8);
    check("post_rst_value", ADC_value_o, 8);
    check("post_rst_valid", ADC_valid_o, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/adc_avg_filter.md
Name: adc_avg_filter

Overview:
- Front-end conditioning stage directly upstream of the fan controller's PID path.
- Accepts raw ADC samples with a valid strobe and block-averages 2^AVG_LOG2 samples.
- Presents the registered average as the controller's ADC_value input, plus a one-cycle update pulse.
- Runs a sensor watchdog: if samples stop arriving, it forces a fail-safe value (full fan demand) and flags a fault.

Parameters:
- ADC_BITWIDTH, 8, width of raw sample and averaged output.
- AVG_LOG2, 2, log2 of window length; window = 2^AVG_LOG2 samples; 0 = pass-through.
- TIMEOUT_CYCLES, 1000, enabled clock cycles without an accepted sample before fault; must be >= 1.
- FAULT_VALUE, 2^ADC_BITWIDTH-1, value driven on ADC_value_o while faulted.

Ports:
- clk_i, input, 1, system clock (1 MHz).
- rstn_i, input, 1, reset, asynchronous, active-low.
- clk_en_i, input, 1, global clock enable; all state advances only when high.
- sample_i, input, ADC_BITWIDTH, raw unsigned ADC sample.
- sample_valid_i, input, 1, sample_i valid this cycle.
- flush_i, input, 1, discard partial window and restart watchdog.
- ADC_value_o, output, ADC_BITWIDTH, registered averaged (or fail-safe) value.
- ADC_valid_o, output, 1, one-cycle pulse when ADC_value_o updates.
- fault_o, output, 1, watchdog fault flag.

Behaviour:
- Reset (rstn_i low, asynchronous, no clock needed): ADC_value_o=0, ADC_valid_o=0, fault_o=0, accumulator=0, sample counter=0, watchdog counter=0, state=NORMAL.
- Sample acceptance: sample_valid_i && clk_en_i && !flush_i.
- Accumulator is unsigned, ADC_BITWIDTH+AVG_LOG2 bits; it cannot overflow by construction.
- Sample counter is AVG_LOG2 bits and counts 0..2^AVG_LOG2-1.
- Window completion: on the edge accepting the sample with counter = 2^AVG_LOG2-1:
  - ADC_value_o <= (acc + sample_i) >> AVG_LOG2, truncating division.
  - ADC_valid_o <= 1.
  - Accumulator and counter are cleared.
- Other accepted samples: acc <= acc + sample_i; counter increments.
- AVG_LOG2 = 0: every accepted sample completes a window. ADC_value_o = sample_i one cycle later, with a valid pulse.
- ADC_valid_o is high for exactly one clk_i cycle after each update, and low on all other cycles, including clk_en_i-low cycles.
- Watchdog counter:
  - Cleared on every accepted sample and on flush_i.
  - Otherwise increments on each clk_en_i cycle, saturating at TIMEOUT_CYCLES.
- State NORMAL -> FAULT: on the edge where the watchdog counter reaches TIMEOUT_CYCLES. On that edge:
  - fault_o <= 1, ADC_value_o <= FAULT_VALUE, ADC_valid_o <= 1 (a single pulse).
  - Accumulator and counter are cleared.
- In FAULT:
  - No further valid pulses from timeout.
  - Samples are accepted and accumulated normally.
  - ADC_value_o holds FAULT_VALUE until a full window completes.
- FAULT -> NORMAL: on completion of a full window. On that edge fault_o <= 0, and the new average is output with a valid pulse.
- flush_i (requires clk_en_i):
  - Clears accumulator, counter and watchdog.
  - Does not change ADC_value_o, fault_o or state.
  - Has priority over a coincident sample, which is discarded.
- clk_en_i low: every register holds, except ADC_valid_o, which clears.
- Reset asserted mid-window: partial accumulation is lost and outputs go to reset values immediately.
- Latency: the last sample of a window is accepted at edge N. The average is visible after edge N, together with ADC_valid_o.

Test Plan:
- AVG_LOG2=2; samples 10, 20, 30, 41 on consecutive enabled cycles -> after the 4th edge ADC_value_o=25 (101>>2), ADC_valid_o high for 1 cycle, fault_o=0.
- Four samples of 255 -> ADC_value_o=255, no overflow. Then four samples of 0 -> ADC_value_o=0.
- TIMEOUT_CYCLES=16; no samples for 16 enabled cycles -> fault_o=1, ADC_value_o=255, exactly one valid pulse. No further pulses over the next 100 cycles.
- From fault, four samples of 100 -> fault_o=0 and ADC_value_o=100 on the 4th edge, with a valid pulse.
- Two samples of 200, then flush_i asserted with sample_valid_i high in the same cycle, then four samples of 40 -> ADC_value_o=40. No output update occurs before the 4th post-flush sample.
- Two samples accepted, then rstn_i pulsed low between clock edges -> ADC_value_o=0, fault_o=0 immediately. The next four samples of 8 -> ADC_value_o=8.
